// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared UART transmit state encodings and line constants
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 25 MHz system clock at 115200 baud
    localparam int UART_DEFAULT_CLKS_PER_BIT = 217;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// rtl/fifo_uart_tx_baud_counter.sv - bit-period counter, tick on the last clk of each bit
module uart_baud_counter
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a FWFT byte FIFO into back-to-back 8N1/8N2 UART frames
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_read_data,
    output logic       fifo_read_en,
    output logic       tx,
    output logic       busy
);

    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    uart_state_t state, state_next;
    logic [7:0]  shift, shift_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic        stop_cnt, stop_cnt_next;
    logic        tx_q, tx_next;
    logic        busy_q;
    logic        tick;
    logic        load;
    logic        last_stop_cycle;
    logic        baud_clear;

    assign last_stop_cycle = (state == STOP) && tick && (stop_cnt == STOP_LAST);
    assign load            = !reset && !fifo_empty && ((state == IDLE) || last_stop_cycle);
    assign fifo_read_en    = load;
    assign tx              = tx_q;
    assign busy            = busy_q;

    // Held at zero while idle so every frame starts on a fresh bit period
    assign baud_clear = (state == IDLE) || load;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;
        tx_next       = tx_q;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = START;
                    shift_next = fifo_read_data;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next   = shift >> 1;
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next    = STOP;
                        stop_cnt_next = 1'b0;
                        tx_next       = UART_IDLE_LEVEL;
                    end else begin
                        tx_next = shift[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        // Chain straight into the next start bit when the FIFO still has data
                        if (load) begin
                            state_next = START;
                            shift_next = fifo_read_data;
                            tx_next    = 1'b0;
                        end else begin
                            state_next = IDLE;
                            tx_next    = UART_IDLE_LEVEL;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= UART_IDLE_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_idx  <= bit_idx_next;
            stop_cnt <= stop_cnt_next;
            tx_q     <= tx_next;
            busy_q   <= (state_next != IDLE);
        end
    end

endmodule
